// File: rtl/phy_timing_pkg.sv
// phy_timing_pkg: shared FSM encoding and OFDM timing constants for PHY sample/symbol counters.
package phy_timing_pkg;
  typedef enum logic {ST_IDLE, ST_COUNT} state_e;
  localparam int N_FFT = 64;
  localparam int N_CP = 16;
  localparam int N_SYM_SAMPLES = N_FFT + N_CP;
  localparam int N_CBPS_BPSK = 48;
  localparam int N_CBPS_QPSK = 96;
  localparam int N_CBPS_16QAM = 192;
  localparam int N_CBPS_64QAM = 288;
  localparam int N_IL_COLS = 16;
  function automatic int il_rows(input int n_cbps);
    return n_cbps / N_IL_COLS;
  endfunction
endpackage

// File: rtl/mod_counter_core.sv
// mod_counter_core: inner sample counter with shadowed modulus applied only on symbol boundaries.
module mod_counter_core #(
  parameter int CNT_W = 8,
  parameter int DEF_MOD = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy_i,
  input  logic             adv_i,
  input  logic             clr_i,
  input  logic             mod_load,
  input  logic [CNT_W-1:0] mod_in,
  input  logic [CNT_W-1:0] tap_in,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             tap_hit,
  output logic             mod_err
);
  logic [CNT_W-1:0] count_q, count_d, mod_q, mod_d, shadow_q, shadow_d;
  logic             pend_q, pend_d, err_q, err_d, load_ok, apply;
  logic [CNT_W:0]   term;
  always_comb begin
    // a zero modulus stands for 2**CNT_W, so the extra bit makes its terminal count all-ones
    term = {mod_q == '0, mod_q} - (CNT_W+1)'(1);
    wrap = busy_i && ({1'b0, count_q} == term);
    tap_hit = busy_i && (count_q == tap_in);
    load_ok = mod_load && (mod_in != CNT_W'(1));
    apply = pend_q && (!busy_i || (count_q == '0 && !adv_i) || (adv_i && wrap));
    count_d = clr_i ? '0 : adv_i ? (wrap ? '0 : count_q + CNT_W'(1)) : count_q;
    mod_d = apply ? shadow_q : mod_q;
    shadow_d = load_ok ? mod_in : shadow_q;
    pend_d = load_ok || (pend_q && !apply);
    err_d = err_q || (mod_load && mod_in == CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      mod_q <= CNT_W'(DEF_MOD);
      shadow_q <= CNT_W'(DEF_MOD);
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_q <= mod_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  assign count = count_q;
  assign mod_err = err_q;
endmodule

// File: rtl/symbol_timing_counter.sv
// symbol_timing_counter: two-level sample/symbol counter with frame end flag and one-shot/free-run modes.
module symbol_timing_counter
  import phy_timing_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int SYM_W = 12,
  parameter int DEF_MOD = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             run,
  input  logic             one_shot,
  input  logic             mod_load,
  input  logic [CNT_W-1:0] mod_in,
  input  logic [CNT_W-1:0] tap_in,
  input  logic [SYM_W-1:0] sym_limit,
  output logic [CNT_W-1:0] count,
  output logic [SYM_W-1:0] sym_count,
  output logic             tap_hit,
  output logic             wrap,
  output logic             frame_done,
  output logic             busy,
  output logic             mod_err
);
  state_e           state_q, state_d;
  logic [SYM_W-1:0] sym_q, sym_d, limit_q, limit_d;
  logic             os_q, os_d, go, adv, last;
  always_comb begin
    go = (state_q == ST_IDLE) && start && !abort;
    busy = state_q == ST_COUNT;
    adv = busy && run && !abort;
    last = (limit_q != '0) && (sym_q == limit_q - SYM_W'(1));
    frame_done = adv && wrap && last;
    state_d = go ? ST_COUNT : (busy && (abort || (frame_done && os_q))) ? ST_IDLE : state_q;
    sym_d = (go || (busy && abort)) ? '0 : (adv && wrap) ? (last ? '0 : sym_q + SYM_W'(1)) : sym_q;
    os_d = go ? one_shot : os_q;
    limit_d = go ? sym_limit : limit_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sym_q <= '0;
      limit_q <= '0;
      os_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q <= sym_d;
      limit_q <= limit_d;
      os_q <= os_d;
    end
  end
  assign sym_count = sym_q;
  mod_counter_core #(.CNT_W(CNT_W), .DEF_MOD(DEF_MOD)) u_core (
    .clk(clk),
    .rst(rst),
    .busy_i(busy),
    .adv_i(adv),
    .clr_i(go || (busy && abort)),
    .mod_load(mod_load),
    .mod_in(mod_in),
    .tap_in(tap_in),
    .count(count),
    .wrap(wrap),
    .tap_hit(tap_hit),
    .mod_err(mod_err)
  );
endmodule
